// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the fetch and data requesters.
// Data wins by default; a starvation guard and a busy timeout keep both moving.
module mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_t;

    state_t        state, nstate;
    logic [SW-1:0] starve, nstarve;
    logic [TW-1:0] tcnt, ntcnt;
    logic [31:0]   laddr, naddr;
    logic [31:0]   ldata, ndata;
    logic          lwr, nwr;
    logic          err_r, nerr;

    logic dreq;
    logic ibusy;
    logic dbusy;

    assign dreq  = dREN | dWEN;
    assign ibusy = (state == IBUSY);
    assign dbusy = (state == DBUSY);
    assign err   = err_r;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
            tcnt   <= '0;
            laddr  <= '0;
            ldata  <= '0;
            lwr    <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= nstate;
            starve <= nstarve;
            tcnt   <= ntcnt;
            laddr  <= naddr;
            ldata  <= ndata;
            lwr    <= nwr;
            err_r  <= nerr;
        end
    end

    always_comb begin
        nstate  = state;
        nstarve = starve;
        ntcnt   = tcnt;
        naddr   = laddr;
        ndata   = ldata;
        nwr     = lwr;
        nerr    = err_r;
        unique case (state)
            IDLE: begin
                ntcnt = '0;
                if (dreq && !(iREN && starve == SMAX)) begin
                    nstate = DBUSY;
                    naddr  = daddr;
                    ndata  = dstore;
                    // a simultaneous read+write is issued as a write
                    nwr    = dWEN;
                    if (iREN) begin
                        nstarve = (starve == SMAX) ? starve : starve + 1'b1;
                    end else begin
                        nstarve = '0;
                    end
                end else if (iREN) begin
                    nstate  = IBUSY;
                    naddr   = iaddr;
                    nwr     = 1'b0;
                    nstarve = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_ready) begin
                    nstate = IDLE;
                end else if (tcnt == TLIM) begin
                    nstate = IDLE;
                    nerr   = 1'b1;
                end else begin
                    ntcnt = tcnt + 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        iload     = '0;
        dhit      = 1'b0;
        dload     = '0;
        unique case (1'b1)
            ibusy: begin
                ram_ren  = 1'b1;
                ram_addr = laddr;
                ihit     = ram_ready;
                iload    = ram_ready ? ram_load : '0;
            end
            dbusy: begin
                ram_ren   = !lwr;
                ram_wen   = lwr;
                ram_addr  = laddr;
                ram_store = lwr ? ldata : '0;
                dhit      = ram_ready;
                dload     = (ram_ready && !lwr) ? ram_load : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requesters and RAM checked each cycle against a
// grant/ownership model of the arbiter.
module tb_mem_arbiter;

    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        err;

    mem_arbiter #(
        .STARVE_MAX(SMAX),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .iload    (iload),
        .dhit     (dhit),
        .dload    (dload),
        .ram_ren  (ram_ren),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_store(ram_store),
        .ram_load (ram_load),
        .ram_ready(ram_ready),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // owner: 0 = nobody, 1 = fetch, 2 = data
    int          owner;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    bit          m_wr;
    bit          m_err;
    int          cyc;
    int          grant_cyc;
    int          streak;
    bit          ifin;
    bit          dfin;
    int          p_i;
    int          p_d;
    int          p_r;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, exp);
        end
    endtask

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic model_reset();
        owner  = 0;
        streak = 0;
        m_err  = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
        ifin   = 1'b0;
        dfin   = 1'b0;
    endtask

    task automatic compare();
        bit bi;
        bit bd;
        bit ih;
        bit dh;
        bi = (owner == 1);
        bd = (owner == 2);
        ih = bi && ram_ready;
        dh = bd && ram_ready;
        check("ram_ren", 32'(ram_ren), 32'(bi || (bd && !m_wr)));
        check("ram_wen", 32'(ram_wen), 32'(bd && m_wr));
        check("ram_addr", ram_addr, (owner != 0) ? m_addr : 32'd0);
        if (owner == 0 || (bd && m_wr))
            check("ram_store", ram_store, (owner != 0) ? m_data : 32'd0);
        check("ihit", 32'(ihit), 32'(ih));
        check("iload", iload, ih ? ram_load : 32'd0);
        check("dhit", 32'(dhit), 32'(dh));
        check("dload", dload, (dh && !m_wr) ? ram_load : 32'd0);
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic update();
        cyc++;
        ifin = 1'b0;
        dfin = 1'b0;
        if (!nRST) return;
        if (owner != 0) begin
            if (ram_ready) begin
                ifin  = (owner == 1);
                dfin  = (owner == 2);
                owner = 0;
            end else if (cyc - grant_cyc == TMO) begin
                m_err = 1'b1;
                owner = 0;
            end
        end else if ((dREN || dWEN) && !(iREN && streak == SMAX)) begin
            owner     = 2;
            m_addr    = daddr;
            m_data    = dstore;
            m_wr      = dWEN;
            grant_cyc = cyc;
            streak    = iREN ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        end else if (iREN) begin
            owner     = 1;
            m_addr    = iaddr;
            m_wr      = 1'b0;
            grant_cyc = cyc;
            streak    = 0;
        end
    endtask

    task automatic drive();
        int k;
        if (ifin) iREN = 1'b0;
        if (dfin) begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
        if (!iREN && roll(p_i)) iREN = 1'b1;
        if (!(dREN || dWEN) && roll(p_d)) begin
            k    = int'($urandom_range(7));
            dREN = (k < 4) || (k == 7);
            dWEN = (k >= 4);
        end
        iaddr     = $urandom;
        daddr     = $urandom;
        dstore    = $urandom;
        ram_ready = roll(p_r);
        ram_load  = $urandom;
    endtask

    task automatic cycle();
        drive();
        #4;
        compare();
        @(posedge CLK);
        update();
        #1;
    endtask

    initial begin
        int n;
        nRST      = 1'b0;
        iREN      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        iaddr     = 32'h40;
        daddr     = 32'h100;
        dstore    = 32'h12345678;
        ram_load  = 32'hDEADBEEF;
        ram_ready = 1'b1;
        cyc       = 0;
        grant_cyc = 0;
        model_reset();

        #12;
        compare();
        @(negedge CLK);
        nRST      = 1'b1;
        ram_ready = 1'b0;
        @(posedge CLK);
        update();
        #1;

        p_i = 50; p_d = 50; p_r = 60;
        repeat (400) cycle();

        // fetch and data always requesting, instant RAM: starvation guard
        p_i = 100; p_d = 100; p_r = 100;
        repeat (60) cycle();

        p_i = 40; p_d = 70; p_r = 100;
        repeat (60) cycle();

        // RAM never answers
        p_i = 100; p_d = 50; p_r = 0;
        repeat (30) cycle();
        check("err_sticky", 32'(err), 32'd1);

        p_i = 0; p_d = 0; p_r = 0;
        dREN = 1'b0;
        dWEN = 1'b0;
        iREN = 1'b1;
        n = 0;
        while (owner != 1 && n < 40) begin
            cycle();
            n++;
        end
        if (owner != 1) check("grant_wait", 32'(ram_ren), 32'd1);

        #2;
        nRST      = 1'b0;
        ram_ready = 1'b1;
        model_reset();
        #1;
        check("rst_ren", 32'(ram_ren), 32'd0);
        check("rst_ihit", 32'(ihit), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        compare();
        @(posedge CLK);
        update();
        #3;
        nRST = 1'b1;
        @(posedge CLK);
        update();
        #1;

        p_i = 0; p_d = 0; p_r = 60;
        repeat (20) cycle();

        p_i = 50; p_d = 50; p_r = 50;
        repeat (300) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM interface between the instruction-fetch requester and the data-access requester of the CPU.
- Sits between the request unit / datapath (iREN, dREN, dWEN) and the RAM model.
- Grants one access at a time and holds it until RAM signals completion. Data access has priority, with a starvation guard for fetch.
- Returns ihit/dhit pulses and load data to the winning requester, and flags RAM accesses that never complete.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced to win.
TIMEOUT, 64, cycles in a busy state without ram_ready before abort and error.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (level, held until ihit)
iaddr  in  32  instruction address
dREN  in  1  data read request (level, held until dhit)
dWEN  in  1  data write request (level, held until dhit)
daddr  in  32  data address
dstore  in  32  data write value
ihit  out  1  fetch complete, one-cycle pulse
iload  out  32  fetched word, valid when ihit=1
dhit  out  1  data access complete, one-cycle pulse
dload  out  32  read word, valid when dhit=1 and the access was a read
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  32  RAM address
ram_store  out  32  RAM write data
ram_load  in  32  RAM read data
ram_ready  in  1  RAM access complete, one-cycle pulse
err  out  1  sticky timeout flag

Behaviour:
- Clocking and reset: one clock, CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - state=IDLE, starvation counter=0, timeout counter=0.
  - Latched addr/data/op = 0.
  - All outputs 0, including err.
- States: IDLE, IBUSY, DBUSY.
- IDLE arbitration (evaluated each cycle):
  - If (dREN|dWEN) and not (iREN and starve==STARVE_MAX): latch daddr/dstore/op, go to DBUSY, increment starve if iREN else clear it.
  - Else if iREN: latch iaddr, go to IBUSY, clear starve.
  - Else stay in IDLE.
- Grant latency: one cycle from request to RAM strobe.
- dREN and dWEN both high: treat as a write; dREN is ignored for that access.
- Busy states:
  - ram_addr/ram_store/ram_ren/ram_wen are driven from latched values only, so requester changes mid-access have no effect.
  - In IDLE all ram_* outputs are 0.
- Completion:
  - In IBUSY with ram_ready=1: ihit=1 and iload=ram_load combinationally in the same cycle; next state IDLE.
  - DBUSY behaves the same way with dhit; dload=ram_load for reads and 0 for writes.
  - The hit/load outputs are 0 in every other cycle.
- Mandatory IDLE turnaround cycle after every completion. A requester still high after its hit cannot be re-granted in that same cycle.
- Timeout:
  - Counter clears on entry to IBUSY/DBUSY and increments each busy cycle without ram_ready.
  - Reaching TIMEOUT-1 with no ready: set err (sticky until reset), return to IDLE, no hit pulse.
  - ram_ready in the same cycle as the limit counts as completion; err is not set.
- Counters:
  - starve saturates at STARVE_MAX.
  - Timeout counter width = $clog2(TIMEOUT)+1; no wrap.
- ram_ready while IDLE: ignored.
- Reset asserted mid-access: immediate return to IDLE; strobes drop asynchronously; no hit is issued.

Test Plan:
- Fetch only: iREN=1, iaddr=0x40, ram_ready pulsed 3 cycles after ram_ren rises with ram_load=0xDEADBEEF -> ram_addr=0x40 one cycle after iREN; ihit=1 and iload=0xDEADBEEF in the ready cycle; IDLE one cycle later; ram_ren=0 in the turnaround cycle.
- Contention: iREN=1, dWEN=1, daddr=0x100, dstore=0x12345678 in the same cycle -> DBUSY first, with ram_wen=1 and ram_store=0x12345678; after dhit and the turnaround, IBUSY with ram_addr=iaddr.
- Starvation: iREN held, dREN re-asserted every IDLE cycle -> exactly 4 data grants, then the 5th grant is fetch; starve reads 0 afterwards.
- Timeout with TIMEOUT=8: dREN=1, ram_ready never pulsed -> err=1 after 8 busy cycles, state IDLE, dhit never asserted; err stays 1 until nRST.
- Async reset in IBUSY: drop nRST between clock edges -> ram_ren=0 immediately, no ihit; after release, iREN=1 re-grants normally.
- Both dREN and dWEN high with ram_ready immediate -> ram_wen=1, ram_ren=0, dhit pulse with dload=0.
